pn_bit_checker: RTL
===================

Name: pn_bit_checker

Overview:
- Receive-side companion to the PN bit-stream generator.
- Regenerates the same 8-bit PN sequence locally and hunts for alignment by slipping its local generator.
- Once locked, counts received bits and bit errors for BER measurement.
- Sits at the demodulator output of the BPSK sim chain, consuming the recovered hard-decision bit.

Parameters:
- SEED, 8'hd7, local LFSR seed; must equal the transmitter seed.
- WIN, 64, bits per hunt/monitor window (power of 2, 16..256).
- HUNT_THR, 2, maximum mismatches in a window to declare lock.
- LOSS_THR, 16, mismatches in a window above which lock is lost.
- CNT_W, 32, width of the bit and error counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  received hard-decision bit.
- bit_vld  in  1  bit_in qualifier; one bit per cycle when high.
- clr_cnt  in  1  synchronous clear of bit_cnt/err_cnt; lock state unaffected.
- locked  out  1  high while in LOCK.
- err_pulse  out  1  one-cycle pulse per mismatched bit while locked.
- bit_cnt  out  CNT_W  valid bits checked while locked.
- err_cnt  out  CNT_W  mismatches while locked.
- slip_cnt  out  8  slips since last entry to HUNT.
- hunt_wrap  out  1  sticky: 255 slips without lock.

Behaviour:
- Reset (async, rst=1): LFSR=SEED, state HUNT, window counter=0, all outputs 0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift toward MSB; identical to PNGen (constants shared).
  - Advances one step per bit_vld cycle; a slip advances two steps in that cycle.
  - Never reaches 0.
- ref_bit = (lfsr > 8'h80), compared against bit_in on each bit_vld cycle; mis = bit_in ^ ref_bit.
- Window: wcnt counts bit_vld cycles 0..WIN-1; werr counts mismatches and saturates at WIN.
- HUNT:
  - At the last bit of a window, if werr (including the current bit) <= HUNT_THR: go to LOCK, locked=1 next cycle.
  - Otherwise, slip on the next bit_vld cycle, clear the window, slip_cnt+1.
  - slip_cnt wraps 254->0 on the 255th slip, which sets hunt_wrap (cleared only by rst).
- LOCK:
  - Every bit_vld cycle: bit_cnt+1; on mismatch err_cnt+1 and err_pulse=1 the next cycle. Output latency is 1 clk from the sampled bit.
  - At window end, if werr > LOSS_THR: go to HUNT, locked=0 next cycle, slip_cnt=0, window cleared. Counters hold their values.
- Counters saturate at all-ones and do not wrap.
- clr_cnt takes precedence over a same-cycle increment; result is 0.
- bit_vld=0: LFSR, window and counters hold; err_pulse=0.
- rst mid-window or mid-lock: immediate return to reset values, including LFSR=SEED.

Decomposition:
- Package pn_pkg: PN_POLY_TAPS, PN_WIDTH=8, PN_THRESH=8'h80, and a state enum {HUNT, LOCK}. This package is shared with the generator side.
- Sub-module pn_lfsr_step: combinational next-state for 1 or 2 steps, selected by a slip input. No other sub-modules.

Test Plan:
1. Generator and checker released from reset together, bit_vld=1, clean loopback -> locked=1 after 64 bits (cycle 65), slip_cnt=0; after 1000 more bits, bit_cnt=1000, err_cnt=0.
2. Generator released 5 cycles before checker -> lock after 5 slips (slip_cnt=5); err_cnt=0 over 500 subsequent bits.
3. Locked stream, invert 3 isolated bits -> err_cnt=3, exactly 3 err_pulse cycles each 1 clk after the bad bit, locked stays 1.
4. Locked stream, then 64 bits of inverted data -> at the window end locked=0 and slip_cnt=0; clean data then relocks with slip_cnt=0.
5. CNT_W=4, inverted bits while locked with LOSS_THR=WIN -> err_cnt sticks at 15; clr_cnt pulse -> 0 next cycle, locked unchanged.
6. Constant bit_in=0 -> slip_cnt cycles to 254, then 0, with hunt_wrap=1; asserting rst mid-hunt -> all outputs 0 and hunt restarts from SEED.

Source files
------------

// File: rtl/pn_pkg.sv
// PN sequence constants, state type and LFSR step.
// Shared by the PN generator and the PN checker.
package pn_pkg;

  localparam int PN_WIDTH = 8;
  // Taps for x^8+x^6+x^5+x^4+1 on a shift-toward-MSB register
  localparam logic [PN_WIDTH-1:0] PN_POLY_TAPS = 8'hb8;
  localparam logic [PN_WIDTH-1:0] PN_THRESH = 8'h80;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } pn_state_t;

  function automatic logic [PN_WIDTH-1:0] pn_step(
    input logic [PN_WIDTH-1:0] s
  );
    return {s[PN_WIDTH-2:0], ^(s & PN_POLY_TAPS)};
  endfunction

endpackage

// File: rtl/pn_lfsr_step.sv
// Combinational LFSR advance by one step,
// or by two steps when slipping.
module pn_lfsr_step
  import pn_pkg::*;
(
  input  logic [PN_WIDTH-1:0] cur,
  input  logic                slip,
  output logic [PN_WIDTH-1:0] nxt
);

  logic [PN_WIDTH-1:0] one;

  assign one = pn_step(cur);
  assign nxt = slip ? pn_step(one) : one;

endmodule

// File: rtl/pn_bit_checker.sv
// PN bit checker: hunts for alignment by slipping the local
// LFSR, then counts checked bits and bit errors while locked.
module pn_bit_checker
  import pn_pkg::*;
#(
  parameter logic [PN_WIDTH-1:0] SEED     = 8'hd7,
  parameter int                  WIN      = 64,
  parameter int                  HUNT_THR = 2,
  parameter int                  LOSS_THR = 16,
  parameter int                  CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       slip_cnt,
  output logic             hunt_wrap
);

  localparam int WW = $clog2(WIN);
  localparam logic [WW:0] HT = (WW+1)'(HUNT_THR);
  localparam logic [WW:0] LT = (WW+1)'(LOSS_THR);
  localparam logic [WW:0] WMAX = (WW+1)'(WIN);
  localparam logic [WW-1:0] LAST = WW'(WIN - 1);

  pn_state_t           state;
  logic [PN_WIDTH-1:0] lfsr;
  logic [PN_WIDTH-1:0] lfsr_nxt;
  logic [WW-1:0]       wcnt;
  logic [WW:0]         werr;
  logic [WW:0]         werr_nxt;
  logic                slip_pend;
  logic                ref_bit;
  logic                mis;
  logic                last;

  pn_lfsr_step u_step (
    .cur  (lfsr),
    .slip (slip_pend),
    .nxt  (lfsr_nxt)
  );

  assign ref_bit  = lfsr > PN_THRESH;
  assign mis      = bit_in ^ ref_bit;
  assign last     = wcnt == LAST;
  assign werr_nxt = (werr == WMAX) ? werr
                  : werr + {{WW{1'b0}}, mis};

  // Hunt/lock state machine, window tally and BER counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      lfsr      <= SEED;
      wcnt      <= '0;
      werr      <= '0;
      slip_pend <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      bit_cnt   <= '0;
      err_cnt   <= '0;
      slip_cnt  <= '0;
      hunt_wrap <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bit_vld) begin
        lfsr      <= lfsr_nxt;
        slip_pend <= 1'b0;
        wcnt      <= wcnt + 1'b1;
        werr      <= werr_nxt;
        case (state)
          HUNT: begin
            if (last) begin
              wcnt <= '0;
              werr <= '0;
              if (werr_nxt <= HT) begin
                state  <= LOCK;
                locked <= 1'b1;
              end else begin
                slip_pend <= 1'b1;
                if (slip_cnt == 8'd254) begin
                  slip_cnt  <= '0;
                  hunt_wrap <= 1'b1;
                end else begin
                  slip_cnt <= slip_cnt + 1'b1;
                end
              end
            end
          end
          LOCK: begin
            err_pulse <= mis;
            if (!(&bit_cnt))
              bit_cnt <= bit_cnt + 1'b1;
            if (mis && !(&err_cnt))
              err_cnt <= err_cnt + 1'b1;
            if (last) begin
              wcnt <= '0;
              werr <= '0;
              if (werr_nxt > LT) begin
                state    <= HUNT;
                locked   <= 1'b0;
                slip_cnt <= '0;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (clr_cnt) begin
        bit_cnt <= '0;
        err_cnt <= '0;
      end
    end
  end

endmodule
